pvz_palette_lut: RTL and testbench
==================================

Name: pvz_palette_lut

Overview:
Parametrised, runtime-writable colour palette for the PvZ sprite and background pipeline. It maps a pixel index to RGB through a 2-stage pipeline. It adds three capabilities: palette rewrite from the game controller, a transparent-index flag for sprite compositing, and a frame-stepped fade to/from black for scene transitions. It sits between the sprite/background ROM index outputs and the VGA colour mux.

Parameters:
INDEX_W, 4, index width; palette depth = 2**INDEX_W entries
COLOR_W, 4, bits per colour channel
LVL_W, 4, fade level resolution; level range 0..2**LVL_W (full = 2**LVL_W)
TRANS_IDX, 0, index flagged transparent
TRANS_EN, 1, 1 = transparency flag active, 0 = flag always 0

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
pix_valid  in  1  pixel index valid
pix_index  in  INDEX_W  pixel palette index
wr_en  in  1  palette write strobe
wr_addr  in  INDEX_W  palette entry to write
wr_data  in  3*COLOR_W  {red, green, blue} write data
frame_tick  in  1  one-cycle pulse per frame (vsync-derived)
fade_start  in  1  one-cycle fade request
fade_dir  in  1  0 = fade out (to black), 1 = fade in (from black)
red, green, blue  out  COLOR_W each  registered output colour
out_valid  out  1  output colour valid
out_transparent  out  1  pixel index equalled TRANS_IDX (when TRANS_EN)
fade_busy  out  1  fade in progress
fade_done  out  1  one-cycle pulse on fade completion

Behaviour:
- Clock and reset: one clock, Clk. Reset_n is asynchronous and active-low.
- Reset values:
  - All outputs 0; level = 2**LVL_W (full brightness); FSM = IDLE.
  - Palette entry i resets to grey {g,g,g}, where g = i scaled to COLOR_W: i>>(INDEX_W-COLOR_W) if INDEX_W>=COLOR_W, else i<<(COLOR_W-INDEX_W).
- Palette storage: register array of 2**INDEX_W x 3*COLOR_W. A write commits at the Clk edge where wr_en=1.
- Pipeline, latency 2 cycles, one pixel per cycle, no stall:
  - S1 registers pix_valid, the index-compare result, and palette[pix_index], read before that edge's write.
  - Read/write collision: a write to the same address in the same cycle as the read gives the OLD entry. The new value is visible to reads issued the following cycle.
  - S2 computes each channel as (c * level) >> LVL_W, using level as registered at this S2 edge, and registers red/green/blue, out_valid and out_transparent.
  - Product width: COLOR_W+LVL_W+1 bits. At level = 2**LVL_W the result equals c exactly; no saturation is needed.
  - When the S1 valid is 0, S2 sets out_valid=0 and holds red/green/blue/out_transparent at their previous values.
- Fade FSM states: IDLE, FADE_OUT, FADE_IN.
  - IDLE + fade_start: fade_dir=0 -> FADE_OUT; fade_dir=1 -> FADE_IN with level forced to 0 on entry. fade_busy=1 from the next cycle.
  - FADE_OUT: each frame_tick decrements level by 1. At the tick that makes level 0: pulse fade_done, go to IDLE, level stays 0 (screen black).
  - FADE_IN: each frame_tick increments level by 1. On reaching 2**LVL_W: pulse fade_done, go to IDLE.
  - fade_start while busy: ignored.
  - fade_start in the same cycle as a frame_tick in IDLE: the state is entered and that tick does not step the level.
  - fade_done is registered and is 1 for exactly one cycle, coincident with the return to IDLE.
- Edge cases:
  - FADE_OUT started at level 0: completes on the first frame_tick (fade_done pulse), level stays 0.
  - A fade in progress does not affect palette writes.
  - Reset mid-fade aborts immediately: IDLE, level full, fade_done not pulsed.

Test Plan:
- Reset, INDEX_W=4/COLOR_W=4: stream indices 0..15 back-to-back -> out_valid 2 cycles later each cycle; entry 5 gives rgb 5,5,5; index 0 gives out_transparent=1, others 0.
- Write entry 3 = 0x963; issue pix_index=3 in the same cycle, then again next cycle -> first output 3,3,3, second output 9,6,3.
- Load entry 7 = 0xFA4, LVL_W=4, fade_dir=0, 8 frame_ticks, then read index 7 -> level 8, rgb 7,5,2; after 16 ticks total -> fade_done pulse once, rgb 0,0,0, fade_busy=0.
- From black, fade_dir=1 with 16 frame_ticks -> level returns to 16, entry 0xFA4 outputs F,A,4; fade_start asserted mid-fade is ignored (tick count unchanged).
- Pix_valid toggled 1,0,1 with indices 2,x,9 -> out_valid 1,0,1; colour held during the gap.
- Assert Reset_n low mid-FADE_OUT at level 5 -> all outputs 0 asynchronously; after release level=16, state IDLE, no fade_done.

Source files
------------

// File: rtl/pvz_palette_lut.sv
// Runtime-writable colour palette with transparency flag and frame-stepped fade to/from black.
// Latency 2 cycles, one pixel per cycle; no backpressure, the pipeline never stalls.
// Writes land at the edge they are strobed; a same-cycle read of that entry returns the old value.
module pvz_palette_lut #(
    parameter int INDEX_W   = 4,
    parameter int COLOR_W   = 4,
    parameter int LVL_W     = 4,
    parameter int TRANS_IDX = 0,
    parameter int TRANS_EN  = 1
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   pix_valid,
    input  logic [INDEX_W-1:0]     pix_index,
    input  logic                   wr_en,
    input  logic [INDEX_W-1:0]     wr_addr,
    input  logic [3*COLOR_W-1:0]   wr_data,
    input  logic                   frame_tick,
    input  logic                   fade_start,
    input  logic                   fade_dir,
    output logic [COLOR_W-1:0]     red,
    output logic [COLOR_W-1:0]     green,
    output logic [COLOR_W-1:0]     blue,
    output logic                   out_valid,
    output logic                   out_transparent,
    output logic                   fade_busy,
    output logic                   fade_done
);

    localparam int DEPTH  = 2**INDEX_W;
    localparam int RGB_W  = 3*COLOR_W;
    localparam int PROD_W = COLOR_W + LVL_W + 1;
    localparam int SH_DN  = (INDEX_W >= COLOR_W) ? (INDEX_W - COLOR_W) : 0;
    localparam int SH_UP  = (INDEX_W <  COLOR_W) ? (COLOR_W - INDEX_W) : 0;
    localparam logic [LVL_W:0] LVL_FULL = (LVL_W+1)'(2**LVL_W);
    localparam logic [LVL_W:0] LVL_ONE  = (LVL_W+1)'(1);

    typedef enum logic [1:0] {IDLE, FADE_OUT, FADE_IN} fade_state_t;

    function automatic logic [COLOR_W-1:0] grey(input int i);
        if (INDEX_W >= COLOR_W)
            return COLOR_W'(i >> SH_DN);
        else
            return COLOR_W'(i << SH_UP);
    endfunction

    // Full-width product keeps c exact at full level, so no saturation is required.
    function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c,
                                                 input logic [LVL_W:0]     lvl);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(c) * PROD_W'(lvl);
        return COLOR_W'(prod >> LVL_W);
    endfunction

    logic [RGB_W-1:0]   pal_q [DEPTH];
    logic               s1_vld_q;
    logic               s1_trans_q;
    logic [RGB_W-1:0]   s1_col_q;
    logic               s1_trans_d;

    logic [COLOR_W-1:0] red_q, green_q, blue_q;
    logic               out_vld_q, out_trans_q;

    fade_state_t        state_q;
    logic [LVL_W:0]     level_q;
    logic               busy_q, done_q;

    assign s1_trans_d = (TRANS_EN != 0) && (pix_index == INDEX_W'(TRANS_IDX));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                pal_q[i] <= {3{grey(i)}};
        end else if (wr_en) begin
            pal_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_vld_q   <= 1'b0;
            s1_trans_q <= 1'b0;
            s1_col_q   <= '0;
        end else begin
            s1_vld_q   <= pix_valid;
            s1_trans_q <= s1_trans_d;
            s1_col_q   <= pal_q[pix_index];
        end
    end

    // Idle slots leave the last colour on the bus so the VGA mux sees a stable value.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
            out_vld_q   <= 1'b0;
            out_trans_q <= 1'b0;
        end else begin
            out_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                red_q       <= scale(s1_col_q[RGB_W-1 -: COLOR_W], level_q);
                green_q     <= scale(s1_col_q[2*COLOR_W-1 -: COLOR_W], level_q);
                blue_q      <= scale(s1_col_q[COLOR_W-1:0], level_q);
                out_trans_q <= s1_trans_q;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            level_q <= LVL_FULL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A tick arriving with the start request is swallowed by the state entry.
                    if (fade_start) begin
                        busy_q <= 1'b1;
                        if (fade_dir) begin
                            state_q <= FADE_IN;
                            level_q <= '0;
                        end else begin
                            state_q <= FADE_OUT;
                        end
                    end
                end
                FADE_OUT: begin
                    if (frame_tick) begin
                        if (level_q <= LVL_ONE) begin
                            level_q <= '0;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            level_q <= level_q - LVL_ONE;
                        end
                    end
                end
                FADE_IN: begin
                    if (frame_tick) begin
                        if (level_q >= LVL_FULL - LVL_ONE) begin
                            level_q <= LVL_FULL;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            level_q <= level_q + LVL_ONE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign red             = red_q;
    assign green           = green_q;
    assign blue            = blue_q;
    assign out_valid       = out_vld_q;
    assign out_transparent = out_trans_q;
    assign fade_busy       = busy_q;
    assign fade_done       = done_q;

endmodule

// File: tb/tb_pvz_palette_lut.sv
// Directed bench for pvz_palette_lut with default parameters (4-bit index/colour/level).
module tb_pvz_palette_lut;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        pix_valid;
    logic [3:0]  pix_index;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [11:0] wr_data;
    logic        frame_tick;
    logic        fade_start;
    logic        fade_dir;
    logic [3:0]  red, green, blue;
    logic        out_valid, out_transparent, fade_busy, fade_done;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int done_at = -1;
    int ftk = 0;

    pvz_palette_lut dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .pix_valid(pix_valid), .pix_index(pix_index),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_tick(frame_tick), .fade_start(fade_start), .fade_dir(fade_dir),
        .red(red), .green(green), .blue(blue),
        .out_valid(out_valid), .out_transparent(out_transparent),
        .fade_busy(fade_busy), .fade_done(fade_done)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rgb(input string tag, input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        chk(tag, {20'h0, red, green, blue}, {20'h0, r, g, b});
    endtask

    task automatic read_px(input logic [3:0] idx);
        pix_valid = 1'b1;
        pix_index = idx;
        tick();
        pix_valid = 1'b0;
        tick();
        chk("read_vld", {31'h0, out_valid}, 32'h1);
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            tick();
            ftk++;
            if (fade_done) begin done_cnt++; done_at = ftk; end
            frame_tick = 1'b0;
            tick();
            if (fade_done) done_cnt++;
        end
    endtask

    initial begin
        Reset_n = 1'b0;
        pix_valid = 1'b0; pix_index = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        frame_tick = 1'b0; fade_start = 1'b0; fade_dir = 1'b0;
        #2;
        chk("rst_rgb", {20'h0, red, green, blue}, 32'h0);
        chk("rst_flags", {28'h0, out_valid, out_transparent, fade_busy, fade_done}, 32'h0);
        tick(); tick();
        Reset_n = 1'b1;
        tick();

        // Stream indices 0..15 back to back against the grey reset palette.
        for (int i = 0; i <= 16; i++) begin
            pix_valid = (i < 16);
            pix_index = 4'(i);
            tick();
            if (i >= 1) begin
                chk("stream_vld", {31'h0, out_valid}, 32'h1);
                chk_rgb("stream_rgb", 4'(i-1), 4'(i-1), 4'(i-1));
                chk("stream_trans", {31'h0, out_transparent}, {31'h0, (i == 1)});
            end
        end
        pix_valid = 1'b0;
        tick();
        chk("gap_vld", {31'h0, out_valid}, 32'h0);
        chk_rgb("gap_hold", 4'hF, 4'hF, 4'hF);

        // Same-cycle write and read of entry 3, then a read the cycle after.
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 12'h963;
        pix_valid = 1'b1; pix_index = 4'd3;
        tick();
        wr_en = 1'b0;
        tick();
        chk_rgb("coll_old", 4'h3, 4'h3, 4'h3);
        pix_valid = 1'b0;
        tick();
        chk_rgb("coll_new", 4'h9, 4'h6, 4'h3);

        // Fade out; the start coincides with a tick, which must not step the level.
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 12'hFA4;
        tick();
        wr_en = 1'b0;
        fade_start = 1'b1; fade_dir = 1'b0; frame_tick = 1'b1;
        tick();
        fade_start = 1'b0; frame_tick = 1'b0;
        chk("fo_busy", {31'h0, fade_busy}, 32'h1);
        ftk = 0; done_cnt = 0; done_at = -1;
        frames(8);
        read_px(4'd7);
        chk_rgb("fo_lvl8", 4'h7, 4'h5, 4'h2);
        chk("fo_busy8", {31'h0, fade_busy}, 32'h1);
        frames(8);
        tick();
        if (fade_done) done_cnt++;
        chk("fo_done_cnt", done_cnt, 32'd1);
        chk("fo_done_at", done_at, 32'd16);
        chk("fo_idle", {31'h0, fade_busy}, 32'h0);
        read_px(4'd7);
        chk_rgb("fo_black", 4'h0, 4'h0, 4'h0);

        // Fade out requested while already black completes on the first tick.
        fade_start = 1'b1; fade_dir = 1'b0;
        tick();
        fade_start = 1'b0;
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        chk("fo0_done", {31'h0, fade_done}, 32'h1);
        tick();
        chk("fo0_pulse", {30'h0, fade_done, fade_busy}, 32'h0);
        read_px(4'd7);
        chk_rgb("fo0_black", 4'h0, 4'h0, 4'h0);

        // Fade in with a stray start request mid-way.
        fade_start = 1'b1; fade_dir = 1'b1;
        tick();
        fade_start = 1'b0;
        chk("fi_busy", {31'h0, fade_busy}, 32'h1);
        ftk = 0; done_cnt = 0; done_at = -1;
        frames(8);
        read_px(4'd7);
        chk_rgb("fi_lvl8", 4'h7, 4'h5, 4'h2);
        fade_start = 1'b1; fade_dir = 1'b1;
        tick();
        fade_start = 1'b0;
        frames(8);
        tick();
        if (fade_done) done_cnt++;
        chk("fi_done_cnt", done_cnt, 32'd1);
        chk("fi_done_at", done_at, 32'd16);
        chk("fi_idle", {31'h0, fade_busy}, 32'h0);
        read_px(4'd7);
        chk_rgb("fi_full", 4'hF, 4'hA, 4'h4);

        // Valid toggling 1,0,1 with indices 2,x,9.
        pix_valid = 1'b1; pix_index = 4'd2;
        tick();
        pix_valid = 1'b0; pix_index = 4'd5;
        tick();
        chk("tog_v1", {31'h0, out_valid}, 32'h1);
        chk_rgb("tog_rgb2", 4'h2, 4'h2, 4'h2);
        pix_valid = 1'b1; pix_index = 4'd9;
        tick();
        chk("tog_v0", {31'h0, out_valid}, 32'h0);
        chk_rgb("tog_hold", 4'h2, 4'h2, 4'h2);
        pix_valid = 1'b0; pix_index = 4'd0;
        tick();
        chk("tog_v2", {31'h0, out_valid}, 32'h1);
        chk_rgb("tog_rgb9", 4'h9, 4'h9, 4'h9);
        chk("tog_trans", {31'h0, out_transparent}, 32'h0);

        // Reset while fading out at level 5.
        fade_start = 1'b1; fade_dir = 1'b0;
        tick();
        fade_start = 1'b0;
        done_cnt = 0;
        frames(11);
        read_px(4'd7);
        chk_rgb("mid_lvl5", 4'h4, 4'h3, 4'h1);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("mid_rst_rgb", {20'h0, red, green, blue}, 32'h0);
        chk("mid_rst_flags", {28'h0, out_valid, out_transparent, fade_busy, fade_done}, 32'h0);
        tick();
        Reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (fade_done) done_cnt++;
        end
        chk("mid_no_done", done_cnt, 32'd0);
        chk("mid_idle", {31'h0, fade_busy}, 32'h0);
        read_px(4'd7);
        chk_rgb("mid_full", 4'h7, 4'h7, 4'h7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
